spi_flash_arb: RTL and testbench

SPI_FLASH_ARB -- requirements
Module: spi_flash_arb

---
 rtl/spi_flash_arb_pkg.sv | 23 ++
 rtl/spi_flash_arb_rr_pick.sv | 36 +++
 rtl/spi_flash_arb.sv | 140 ++++++++++++++
 tb/tb_spi_flash_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_arb_pkg.sv
// Shared definitions for the SPI flash arbiter: state encoding, idle pin
// levels and a small index-wrapping helper.
package spi_flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // Flash pin levels whenever nobody owns the bus (deselected, clock parked low).
    localparam logic IDLE_CSEL = 1'b1;
    localparam logic IDLE_CLK  = 1'b0;
    localparam logic IDLE_MOSI = 1'b0;
    localparam logic IDLE_MISO = 1'b1;

    localparam int GAP_CNT_W = 8;

    function automatic int wrap_add(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/spi_flash_arb_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr,
// wrapping around; returns a one-hot winner (all zero when nobody is eligible).
module rr_pick
    import spi_flash_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

    logic [NUM_REQ-1:0] eligible;
    logic               found;
    int                 idx;

    assign eligible = req & ~mask;

    // NOTE: every variable assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = wrap_add(int'(ptr), k, NUM_REQ);
            if (!found && eligible[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_flash_arb.sv
// Arbitrates one SPI flash between NUM_REQ requesters: round-robin grant,
// enforced chip-select gap between owners and an optional hold watchdog.
module spi_flash_arb
    import spi_flash_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 4,
    parameter int HOLD_LIMIT = 0
) (
    input  logic               clk_48mhz,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    input  logic [NUM_REQ-1:0] req_csel,
    input  logic [NUM_REQ-1:0] req_clk,
    input  logic [NUM_REQ-1:0] req_mosi,
    output logic [NUM_REQ-1:0] req_miso,
    output logic               spi_csel,
    output logic               spi_clk,
    output logic               spi_mosi,
    input  logic               spi_miso,
    output logic               busy,
    output logic               timeout
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = (HOLD_LIMIT == 0) ? 1 : $clog2(HOLD_LIMIT + 1);

    localparam logic [HOLD_W-1:0]    HOLD_MAX  = HOLD_W'(HOLD_LIMIT);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'((HOLD_LIMIT == 0) ? 0 : HOLD_LIMIT - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD  = GAP_CNT_W'(GAP_CYCLES - 1);

    arb_state_t           state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_REQ-1:0]   winner;
    logic [NUM_REQ-1:0]   mask;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic                 wd_fire;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .mask   (mask),
        .ptr    (ptr),
        .winner (winner)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) win_idx = IDX_W'(i);
        end
    end

    // The owner has held the bus for HOLD_LIMIT cycles on this edge.
    assign wd_fire = (HOLD_LIMIT != 0) && (state == OWN) && req[owner] && (hold_cnt == HOLD_LAST);

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            ptr      <= '0;
            mask     <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= wd_fire;
            // A revoked owner stays masked until it lets go of its request.
            mask    <= (mask & req) | (wd_fire ? grant : '0);

            case (state)
                IDLE: begin
                    if (|winner) begin
                        state    <= OWN;
                        grant    <= winner;
                        owner    <= win_idx;
                        ptr      <= IDX_W'(wrap_add(int'(win_idx), 1, NUM_REQ));
                        hold_cnt <= '0;
                    end
                end

                OWN: begin
                    if (!req[owner] || wd_fire) begin
                        state   <= GAP;
                        grant   <= '0;
                        gap_cnt <= GAP_LOAD;
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Flash pins come straight through the mux from the owner; grant is zero
    // outside OWN (and clears asynchronously on reset), which parks the pins.
    always_comb begin
        spi_csel = IDLE_CSEL;
        spi_clk  = IDLE_CLK;
        spi_mosi = IDLE_MOSI;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                spi_csel = req_csel[i];
                spi_clk  = req_clk[i];
                spi_mosi = req_mosi[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_miso[i] = grant[i] ? spi_miso : IDLE_MISO;
        end
    end

endmodule

// File: tb/tb_spi_flash_arb.sv
// Directed bench for spi_flash_arb: two requesters, 4-cycle gap, 16-cycle watchdog.
module tb_spi_flash_arb;

    localparam int NUM_REQ    = 2;
    localparam int GAP_CYCLES = 4;
    localparam int HOLD_LIMIT = 16;

    logic               clk_48mhz;
    logic               reset_n;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] req_csel;
    logic [NUM_REQ-1:0] req_clk;
    logic [NUM_REQ-1:0] req_mosi;
    logic [NUM_REQ-1:0] req_miso;
    logic               spi_csel;
    logic               spi_clk;
    logic               spi_mosi;
    logic               spi_miso;
    logic               busy;
    logic               timeout;

    int errors = 0;
    int checks = 0;

    spi_flash_arb #(
        .NUM_REQ    (NUM_REQ),
        .GAP_CYCLES (GAP_CYCLES),
        .HOLD_LIMIT (HOLD_LIMIT)
    ) dut (
        .clk_48mhz (clk_48mhz),
        .reset_n   (reset_n),
        .req       (req),
        .grant     (grant),
        .req_csel  (req_csel),
        .req_clk   (req_clk),
        .req_mosi  (req_mosi),
        .req_miso  (req_miso),
        .spi_csel  (spi_csel),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk_48mhz = 1'b0;
    always #10 clk_48mhz = ~clk_48mhz;

    // One rising edge, then settle on the falling edge where outputs are sampled
    // and new inputs are driven.
    task automatic tick();
        @(posedge clk_48mhz);
        @(negedge clk_48mhz);
    endtask

    task automatic do_reset();
        req      = '0;
        req_csel = '1;
        req_clk  = '0;
        req_mosi = '0;
        spi_miso = 1'b1;
        reset_n  = 1'b0;
        tick();
        reset_n  = 1'b1;
    endtask

    task automatic flush();
        req      = '0;
        req_csel = '1;
        req_clk  = '0;
        req_mosi = '0;
        repeat (GAP_CYCLES + 3) tick();
    endtask

    task automatic test_reset();
        req      = '0;
        req_csel = '0;
        req_clk  = '1;
        req_mosi = '1;
        spi_miso = 1'b0;
        reset_n  = 1'b0;
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        checks++; if ({spi_csel, spi_clk, spi_mosi} !== 3'b100) begin
            errors++; $display("FAIL reset_pins: csel/clk/mosi got %b want 100", {spi_csel, spi_clk, spi_mosi});
        end
        checks++; if (req_miso !== 2'b11) begin errors++; $display("FAIL reset_miso: got %b want 11", req_miso); end
        @(negedge clk_48mhz);
        do_reset();
    endtask

    task automatic test_single();
        req      = 2'b01;
        req_csel = 2'b11;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        req_csel = 2'b10;
        req_clk  = 2'b01;
        req_mosi = 2'b01;
        #1;
        checks++; if ({spi_csel, spi_clk, spi_mosi} !== 3'b011) begin
            errors++; $display("FAIL single_pins_a: csel/clk/mosi got %b want 011", {spi_csel, spi_clk, spi_mosi});
        end
        req_csel = 2'b00;
        req_clk  = 2'b10;
        req_mosi = 2'b10;
        #1;
        checks++; if ({spi_csel, spi_clk, spi_mosi} !== 3'b000) begin
            errors++; $display("FAIL single_pins_b: csel/clk/mosi got %b want 000", {spi_csel, spi_clk, spi_mosi});
        end
        spi_miso = 1'b0;
        #1;
        checks++; if (req_miso !== 2'b10) begin errors++; $display("FAIL single_miso: got %b want 10", req_miso); end
        spi_miso = 1'b1;
        @(negedge clk_48mhz);
        // Requester drops its request but keeps driving csel low: the gap must park the pins.
        req      = 2'b00;
        req_clk  = 2'b11;
        req_mosi = 2'b11;
        for (int i = 0; i < GAP_CYCLES; i++) begin
            tick();
            checks++; if ({busy, grant, spi_csel, spi_clk, spi_mosi} !== 6'b100100) begin
                errors++; $display("FAIL single_gap%0d: busy/grant/csel/clk/mosi got %b want 100100", i,
                                   {busy, grant, spi_csel, spi_clk, spi_mosi});
            end
        end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy got %b want 0", busy); end
        flush();
    endtask

    task automatic test_contention();
        int n;
        do_reset();
        req = 2'b11;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cont_first: got %b want 01", grant); end
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cont_hold: got %b want 01", grant); end
        req = 2'b10;
        tick();
        checks++; if ({busy, grant} !== 3'b100) begin errors++; $display("FAIL cont_gap0: busy/grant got %b want 100", {busy, grant}); end
        // Requester 0 comes back during the gap; it must wait, and the pointer now favours 1.
        req = 2'b11;
        for (int i = 1; i < GAP_CYCLES; i++) begin
            tick();
            checks++; if ({busy, grant} !== 3'b100) begin
                errors++; $display("FAIL cont_gap%0d: busy/grant got %b want 100", i, {busy, grant});
            end
        end
        tick();
        checks++; if ({busy, grant} !== 3'b000) begin errors++; $display("FAIL cont_idle: busy/grant got %b want 000", {busy, grant}); end
        tick();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL cont_second: got %b want 10", grant); end
        req = 2'b01;
        n = 0;
        tick();
        while (grant === 2'b00 && n < 20) begin tick(); n++; end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cont_third: got %b want 01 after %0d cycles", grant, n); end
        flush();
    endtask

    task automatic test_fairness();
        logic [1:0] exp;
        int n;
        do_reset();
        req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp = (t % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            tick();
            while (grant === 2'b00 && n < 20) begin tick(); n++; end
            checks++; if (grant !== exp) begin errors++; $display("FAIL fair_%0d: got %b want %b", t, grant, exp); end
            repeat (7) tick();
            req = req & ~grant;
            tick();
            req = 2'b11;
        end
        flush();
    endtask

    task automatic test_watchdog();
        int n;
        logic held;
        logic regrant;
        do_reset();
        req = 2'b11;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL wd_grant: got %b want 01", grant); end
        held = 1'b1;
        for (int i = 1; i < HOLD_LIMIT; i++) begin
            tick();
            if (grant !== 2'b01 || timeout !== 1'b0) held = 1'b0;
        end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL wd_hold: grant not held %0d cycles, got %b", HOLD_LIMIT, grant); end
        tick();
        checks++; if ({grant, timeout, busy} !== 4'b0011) begin
            errors++; $display("FAIL wd_revoke: grant/timeout/busy got %b want 0011", {grant, timeout, busy});
        end
        tick();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_pulse: timeout got %b want 0", timeout); end
        n = 0;
        while (grant === 2'b00 && n < 20) begin tick(); n++; end
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL wd_next: got %b want 10", grant); end
        req = 2'b01;
        regrant = 1'b0;
        repeat (GAP_CYCLES + 8) begin
            tick();
            if (grant !== 2'b00) regrant = 1'b1;
        end
        checks++; if (regrant !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL wd_masked: regrant=%b busy=%b want 0 0", regrant, busy);
        end
        req = 2'b00;
        tick();
        req = 2'b01;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL wd_unmask: got %b want 01", grant); end
        flush();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 2'b01;
        tick();
        req_csel = 2'b10;
        #1;
        checks++; if (spi_csel !== 1'b0) begin errors++; $display("FAIL mid_own_csel: got %b want 0", spi_csel); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({spi_csel, grant, busy} !== 4'b1000) begin
            errors++; $display("FAIL mid_async: csel/grant/busy got %b want 1000", {spi_csel, grant, busy});
        end
        @(negedge clk_48mhz);
        reset_n  = 1'b1;
        req      = 2'b10;
        req_csel = 2'b01;
        tick();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL mid_regrant: got %b want 10", grant); end
    endtask

    task automatic test_miso();
        spi_miso = 1'b0;
        #1;
        checks++; if (req_miso !== 2'b01) begin errors++; $display("FAIL miso_low: got %b want 01", req_miso); end
        spi_miso = 1'b1;
        #1;
        checks++; if (req_miso !== 2'b11) begin errors++; $display("FAIL miso_high: got %b want 11", req_miso); end
        @(negedge clk_48mhz);
        flush();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_watchdog();
        test_reset_mid();
        test_miso();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
